data_sramlike_master: RTL and testbench
=======================================

DATA_SRAMLIKE_MASTER -- requirements
Module: data_sramlike_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-002 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port clk SHALL be: input, 1 bit, clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-005 Port mem_en SHALL be: input, 1 bit, pipeline memory access request; held by the pipeline while stall=1.
REQ-006 Port mem_wen SHALL be: input, 4 bits, byte write enables; 0 means read.
REQ-007 Port mem_size SHALL be: input, 2 bits, access size (0 byte, 1 half, 2 word).
REQ-008 Port mem_addr SHALL be: input, ADDR_W bits, access address.
REQ-009 Port mem_wdata SHALL be: input, DATA_W bits, store data.
REQ-010 Port longest_stall SHALL be: input, 1 bit, pipeline-wide stall; high while any unit still stalls.
REQ-011 Port mem_rdata SHALL be: output, DATA_W bits, captured load data.
REQ-012 Port stall SHALL be: output, 1 bit, this unit's stall request to the pipeline.
REQ-013 sram-like initiator ports SHALL be: data_req out 1; data_wr out 1; data_size out 2; data_addr out ADDR_W; data_wdata out DATA_W; data_rdata in DATA_W; data_addr_ok in 1; data_data_ok in 1.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-015 data_req SHALL be 1 in ADDR, and in IDLE when mem_en=1; it SHALL be 0 otherwise.
REQ-016 data_wr SHALL equal |mem_wen.
REQ-017 data_size, data_addr and data_wdata SHALL pass through combinationally from mem_size, mem_addr and mem_wdata.
REQ-018 In IDLE with mem_en=1, the next state SHALL be: DONE if addr_ok=1 and data_ok=1; DATA if only addr_ok=1; ADDR otherwise.
REQ-019 In ADDR, the next state SHALL be: DATA on addr_ok=1; DONE on addr_ok=1 with data_ok=1; otherwise stay in ADDR with data_req held at 1, even if mem_en drops (no request withdrawal).
REQ-020 In DATA, data_ok=1 SHALL move the FSM to DONE if mem_en=1, or to IDLE if mem_en=0 (flushed access; data is discarded).
REQ-021 In DONE, longest_stall=0 SHALL move the FSM to IDLE; otherwise it stays in DONE.
REQ-022 mem_rdata SHALL be loaded from data_rdata on every cycle where data_ok=1 is accepted per REQ-018 to REQ-020, including writes; it holds otherwise.
REQ-023 stall SHALL equal mem_en AND (state != DONE) AND NOT (state in {IDLE, ADDR, DATA} with data_ok accepted this cycle); minimum stall for a 0-wait responder is therefore 0 cycles.
REQ-024 data_ok SHALL be ignored in IDLE without a request and in DONE; addr_ok SHALL be ignored outside IDLE/ADDR.
REQ-025 At most one transaction SHALL be outstanding; no new data_req is issued until DONE->IDLE or DATA->IDLE.

Reset
REQ-026 rst=1 SHALL asynchronously force: state IDLE, mem_rdata 0, data_req 0 (mem_en notwithstanding while rst=1), stall 0.
REQ-027 Reset mid-transaction SHALL abandon the access; a late data_ok after reset release SHALL be ignored per REQ-024.

Verification
REQ-028 Read, responder with 1-cycle addr_ok and 2-cycle data_ok: mem_en=1, wen=0, addr=0x1000, data_rdata=0xDEADBEEF -> data_req high for 2 cycles, stall high until data_ok, mem_rdata=0xDEADBEEF, DONE held while longest_stall=1.
REQ-029 Zero-wait: addr_ok=data_ok=1 in the same cycle as mem_en -> stall=0 that cycle, FSM goes to DONE, mem_rdata updated.
REQ-030 Word write: wen=4'b1111, size=2, wdata=0x12345678 -> data_wr=1, data_size=2, data_wdata=0x12345678, one request only.
REQ-031 Flush: mem_en drops while in ADDR -> data_req stays 1 until addr_ok; after data_ok the FSM returns to IDLE, mem_rdata is unchanged in intent, stall=0.
REQ-032 Reset while in DATA, then a stray data_ok=1 -> state IDLE, mem_rdata=0, no data_req.
REQ-033 Back-to-back: second mem_en while in DONE with longest_stall=1 -> no new data_req until longest_stall=0.

Source files
------------

// File: rtl/data_sramlike_master_if.sv
// data_sramlike_master_if: sram-like initiator/responder bus bundle
interface data_sramlike_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/data_sramlike_master.sv
// data_sramlike_master: bridges pipeline memory accesses onto an sram-like bus,
// one outstanding transaction, holding results in DONE until the pipeline advances.
module data_sramlike_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en,
  input  logic [3:0]           mem_wen,
  input  logic [1:0]           mem_size,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 longest_stall,
  output logic [DATA_W-1:0]    mem_rdata,
  output logic                 stall,
  data_sramlike_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic accept;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (mem_en) begin
        accept  = bus.data_addr_ok & bus.data_data_ok;
        state_d = accept ? DONE : bus.data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        accept  = bus.data_addr_ok & bus.data_data_ok;
        state_d = accept ? DONE : bus.data_addr_ok ? DATA : ADDR;
      end
      DATA: begin
        accept  = bus.data_data_ok;
        state_d = !bus.data_data_ok ? DATA : mem_en ? DONE : IDLE;
      end
      default: state_d = longest_stall ? DONE : IDLE;
    endcase
    mem_rdata_d = accept ? bus.data_rdata : mem_rdata_q;
  end
  // reset gates the combinational outputs so nothing leaks while rst is held
  assign bus.data_req   = !rst & ((state_q == ADDR) | ((state_q == IDLE) & mem_en));
  assign bus.data_wr    = |mem_wen;
  assign bus.data_size  = mem_size;
  assign bus.data_addr  = mem_addr;
  assign bus.data_wdata = mem_wdata;
  assign stall          = !rst & mem_en & (state_q != DONE) & !accept;
  assign mem_rdata      = mem_rdata_q;
endmodule

// File: tb/tb_data_sramlike_master.sv
// tb_data_sramlike_master: directed cycle-level stimulus with a load-data scoreboard
module tb_data_sramlike_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        longest_stall;
  logic [31:0] mem_rdata;
  logic        stall;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  data_sramlike_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_sramlike_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .longest_stall(longest_stall),
    .mem_rdata(mem_rdata), .stall(stall), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_sb(input string tag);
    if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    else chk(tag, mem_rdata, exp_q.pop_front());
  endtask

  task automatic resp(input logic a, input logic d);
    bus.data_addr_ok = a;
    bus.data_data_ok = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b1; mem_wen = '0; mem_size = 2'd2; mem_addr = '0;
    mem_wdata = '0; longest_stall = 1'b0;
    bus.data_rdata = '0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    repeat (2) tick();
    chk("rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    mem_en = 1'b0;
    rst = 1'b0;
    tick();
    // read: addr_ok one cycle late, data_ok two cycles after that
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h1000; longest_stall = 1'b1;
    bus.data_rdata = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    resp(0, 0);
    chk("rd_req0", {31'd0, bus.data_req}, 32'd1);
    chk("rd_stall0", {31'd0, stall}, 32'd1);
    chk("rd_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("rd_addr", bus.data_addr, 32'h1000);
    tick(); resp(1, 0);
    chk("rd_req1", {31'd0, bus.data_req}, 32'd1);
    chk("rd_stall1", {31'd0, stall}, 32'd1);
    tick(); resp(0, 0);
    chk("rd_req2", {31'd0, bus.data_req}, 32'd0);
    chk("rd_stall2", {31'd0, stall}, 32'd1);
    tick(); resp(0, 1);
    chk("rd_stall_dok", {31'd0, stall}, 32'd0);
    tick(); resp(0, 0);
    chk_sb("rd_rdata");
    chk("rd_done_stall", {31'd0, stall}, 32'd0);
    chk("rd_done_req", {31'd0, bus.data_req}, 32'd0);
    tick();
    chk("rd_done_hold", {31'd0, bus.data_req}, 32'd0);
    mem_en = 1'b0; longest_stall = 1'b0;
    tick();
    // zero-wait responder
    mem_en = 1'b1; mem_addr = 32'h2000; longest_stall = 1'b1;
    bus.data_rdata = 32'hCAFEF00D; exp_q.push_back(32'hCAFEF00D);
    resp(1, 1);
    chk("zw_req", {31'd0, bus.data_req}, 32'd1);
    chk("zw_stall", {31'd0, stall}, 32'd0);
    tick(); resp(0, 0);
    chk_sb("zw_rdata");
    chk("zw_done_req", {31'd0, bus.data_req}, 32'd0);
    mem_en = 1'b0; longest_stall = 1'b0;
    tick();
    // word write, data returned on the addr_ok cycle from ADDR
    mem_en = 1'b1; mem_wen = 4'hF; mem_size = 2'd2; mem_addr = 32'h2004;
    mem_wdata = 32'h12345678; longest_stall = 1'b1;
    bus.data_rdata = 32'hA5A5A5A5; exp_q.push_back(32'hA5A5A5A5);
    resp(0, 0);
    chk("wr_wr", {31'd0, bus.data_wr}, 32'd1);
    chk("wr_size", {30'd0, bus.data_size}, 32'd2);
    chk("wr_wdata", bus.data_wdata, 32'h12345678);
    tick(); resp(1, 1);
    chk("wr_req_addr", {31'd0, bus.data_req}, 32'd1);
    chk("wr_stall", {31'd0, stall}, 32'd0);
    tick(); resp(0, 0);
    chk("wr_single_req", {31'd0, bus.data_req}, 32'd0);
    chk_sb("wr_rdata");
    mem_en = 1'b0; mem_wen = 4'h0; longest_stall = 1'b0;
    tick();
    // flush while in ADDR: request is not withdrawn, ends in IDLE
    mem_en = 1'b1; mem_addr = 32'h3000; longest_stall = 1'b1;
    bus.data_rdata = 32'h55AA55AA;
    resp(0, 0);
    tick();
    mem_en = 1'b0; resp(0, 0);
    chk("fl_req_hold", {31'd0, bus.data_req}, 32'd1);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick(); resp(1, 0);
    chk("fl_req_aok", {31'd0, bus.data_req}, 32'd1);
    tick(); resp(0, 1);
    chk("fl_req_data", {31'd0, bus.data_req}, 32'd0);
    chk("fl_stall_data", {31'd0, stall}, 32'd0);
    tick(); resp(0, 0);
    chk("fl_idle_req", {31'd0, bus.data_req}, 32'd0);
    // a new request with longest_stall still high proves the FSM is in IDLE
    mem_en = 1'b1; mem_addr = 32'h4000; #1;
    chk("fl_new_req", {31'd0, bus.data_req}, 32'd1);
    tick(); resp(1, 0);
    tick(); resp(0, 0);
    // reset while in DATA, then a stray data_ok
    rst = 1'b1; #1;
    chk("rs_rdata", mem_rdata, 32'd0);
    chk("rs_req", {31'd0, bus.data_req}, 32'd0);
    chk("rs_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0; mem_en = 1'b0; longest_stall = 1'b0;
    bus.data_rdata = 32'hBADBAD00; resp(0, 1);
    chk("rs_stray_req", {31'd0, bus.data_req}, 32'd0);
    tick(); resp(0, 0);
    chk("rs_stray_rdata", mem_rdata, 32'd0);
    // back-to-back: second request waits in DONE for longest_stall to fall
    mem_en = 1'b1; mem_addr = 32'h5000; longest_stall = 1'b1;
    bus.data_rdata = 32'h01020304; exp_q.push_back(32'h01020304);
    resp(1, 1);
    tick(); resp(0, 0);
    chk_sb("bb_rdata1");
    mem_addr = 32'h6000;
    chk("bb_req_blk0", {31'd0, bus.data_req}, 32'd0);
    tick();
    chk("bb_req_blk1", {31'd0, bus.data_req}, 32'd0);
    chk("bb_stall_done", {31'd0, stall}, 32'd0);
    longest_stall = 1'b0; #1;
    chk("bb_req_blk2", {31'd0, bus.data_req}, 32'd0);
    tick();
    bus.data_rdata = 32'h0BADF00D; exp_q.push_back(32'h0BADF00D);
    resp(0, 0);
    chk("bb_req2", {31'd0, bus.data_req}, 32'd1);
    chk("bb_stall2", {31'd0, stall}, 32'd1);
    resp(1, 1);
    chk("bb_stall2_zw", {31'd0, stall}, 32'd0);
    tick(); resp(0, 0);
    chk_sb("bb_rdata2");
    mem_en = 1'b0;
    tick();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
